// File: rtl/ps2_line_buffer.sv
// ps2_line_buffer: turns PS/2 set-2 scan-code bytes into an uppercase ASCII
// line. Characters collect left-aligned in edit_line (char 0 in the top
// byte). Enter copies the line to input_line and pulses line_ready.
//
// Byte interface: a byte is consumed on every rising clock edge where
// ps2_byte_valid is high. There is no back-pressure, so every strobe is taken,
// including strobes on consecutive cycles. line_ready is a one-cycle
// qualifier for input_line, and both carry the new value on the same cycle.
//
// Optional build macro PS2_LINE_KEYPAD_EN: when it is defined, keypad digits
// count as printable keys and keypad Enter (E0 5A) commits the line.
// fsm_state exposes the prefix decoder state (0 idle, 1 after E0, 2 after F0).
module ps2_line_buffer #(
  parameter int MAX_CHARS = 32
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic [7:0]             ps2_byte,
  input  logic                   ps2_byte_valid,
  output logic [8*MAX_CHARS-1:0] input_line,
  output logic                   line_ready,
  output logic [8*MAX_CHARS-1:0] edit_line,
  output logic [5:0]             edit_len,
  output logic                   overflow,
  output logic [1:0]             fsm_state
);

  localparam int         W       = 8 * MAX_CHARS;
  localparam logic [5:0] MAX_LEN = 6'(MAX_CHARS);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXT   = 2'd1,
    ST_BREAK = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   input_line_q, input_line_d;
  logic [W-1:0]   edit_line_q, edit_line_d;
  logic [5:0]     edit_len_q, edit_len_d;
  logic           line_ready_q, line_ready_d;
  logic           overflow_q, overflow_d;

  logic [7:0]     key_ascii;
  logic           key_print;
  logic           make_ev;
  logic           ext_ev;
  logic           enter_ev;
  logic [5:0]     len_minus;

  // Map a make code to its uppercase ASCII byte (0 means not printable)
  always_comb begin
    key_ascii = 8'h00;
    case (ps2_byte)
      8'h1C: key_ascii = 8'h41; // A
      8'h32: key_ascii = 8'h42;
      8'h21: key_ascii = 8'h43;
      8'h23: key_ascii = 8'h44;
      8'h24: key_ascii = 8'h45;
      8'h2B: key_ascii = 8'h46;
      8'h34: key_ascii = 8'h47;
      8'h33: key_ascii = 8'h48;
      8'h43: key_ascii = 8'h49;
      8'h3B: key_ascii = 8'h4A;
      8'h42: key_ascii = 8'h4B;
      8'h4B: key_ascii = 8'h4C;
      8'h3A: key_ascii = 8'h4D;
      8'h31: key_ascii = 8'h4E;
      8'h44: key_ascii = 8'h4F;
      8'h4D: key_ascii = 8'h50;
      8'h15: key_ascii = 8'h51;
      8'h2D: key_ascii = 8'h52;
      8'h1B: key_ascii = 8'h53;
      8'h2C: key_ascii = 8'h54;
      8'h3C: key_ascii = 8'h55;
      8'h2A: key_ascii = 8'h56;
      8'h1D: key_ascii = 8'h57;
      8'h22: key_ascii = 8'h58;
      8'h35: key_ascii = 8'h59;
      8'h1A: key_ascii = 8'h5A; // Z
      8'h45: key_ascii = 8'h30; // 0
      8'h16: key_ascii = 8'h31;
      8'h1E: key_ascii = 8'h32;
      8'h26: key_ascii = 8'h33;
      8'h25: key_ascii = 8'h34;
      8'h2E: key_ascii = 8'h35;
      8'h36: key_ascii = 8'h36;
      8'h3D: key_ascii = 8'h37;
      8'h3E: key_ascii = 8'h38;
      8'h46: key_ascii = 8'h39; // 9
      8'h29: key_ascii = 8'h20; // space
`ifdef PS2_LINE_KEYPAD_EN
      8'h70: key_ascii = 8'h30;
      8'h69: key_ascii = 8'h31;
      8'h72: key_ascii = 8'h32;
      8'h7A: key_ascii = 8'h33;
      8'h6B: key_ascii = 8'h34;
      8'h73: key_ascii = 8'h35;
      8'h74: key_ascii = 8'h36;
      8'h6C: key_ascii = 8'h37;
      8'h75: key_ascii = 8'h38;
      8'h7D: key_ascii = 8'h39;
`endif
      default: key_ascii = 8'h00;
    endcase
    key_print = (key_ascii != 8'h00);
  end

  // Prefix decoder state register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Prefix decoder next state: only a valid byte moves it
  always_comb begin
    state_d = state_q;
    if (ps2_byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (ps2_byte == 8'hF0)      state_d = ST_BREAK;
          else if (ps2_byte == 8'hE0) state_d = ST_EXT;
          else                        state_d = ST_IDLE;
        end
        ST_EXT: begin
          if (ps2_byte == 8'hF0) state_d = ST_BREAK;
          else                   state_d = ST_IDLE;
        end
        ST_BREAK: state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Key events and line-editing next values derived from decoder state
  always_comb begin
    make_ev = ps2_byte_valid && (state_q == ST_IDLE) &&
              (ps2_byte != 8'hF0) && (ps2_byte != 8'hE0);
    ext_ev  = ps2_byte_valid && (state_q == ST_EXT) && (ps2_byte != 8'hF0);
`ifdef PS2_LINE_KEYPAD_EN
    enter_ev = (make_ev || ext_ev) && (ps2_byte == 8'h5A);
`else
    enter_ev = make_ev && (ps2_byte == 8'h5A);
`endif
    len_minus = edit_len_q - 6'd1;

    input_line_d = input_line_q;
    edit_line_d  = edit_line_q;
    edit_len_d   = edit_len_q;
    overflow_d   = overflow_q;
    line_ready_d = 1'b0;

    if (enter_ev) begin
      // Empty lines are never published
      if (edit_len_q != 6'd0) begin
        input_line_d = edit_line_q;
        line_ready_d = 1'b1;
        edit_line_d  = '0;
        edit_len_d   = 6'd0;
        overflow_d   = 1'b0;
      end
    end else if (make_ev) begin
      if (key_print) begin
        if (edit_len_q < MAX_LEN) begin
          for (int i = 0; i < MAX_CHARS; i++) begin
            if (edit_len_q == 6'(i)) edit_line_d[8*(MAX_CHARS-1-i) +: 8] = key_ascii;
          end
          edit_len_d = edit_len_q + 6'd1;
        end else begin
          overflow_d = 1'b1;
        end
      end else if (ps2_byte == 8'h66) begin
        if (edit_len_q != 6'd0) begin
          for (int i = 0; i < MAX_CHARS; i++) begin
            if (len_minus == 6'(i)) edit_line_d[8*(MAX_CHARS-1-i) +: 8] = 8'h00;
          end
          edit_len_d = len_minus;
        end
      end else if (ps2_byte == 8'h76) begin
        edit_line_d = '0;
        edit_len_d  = 6'd0;
        overflow_d  = 1'b0;
      end
    end
  end

  // Line registers
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      input_line_q <= '0;
      edit_line_q  <= '0;
      edit_len_q   <= 6'd0;
      line_ready_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      input_line_q <= input_line_d;
      edit_line_q  <= edit_line_d;
      edit_len_q   <= edit_len_d;
      line_ready_q <= line_ready_d;
      overflow_q   <= overflow_d;
    end
  end

  assign input_line = input_line_q;
  assign edit_line  = edit_line_q;
  assign edit_len   = edit_len_q;
  assign line_ready = line_ready_q;
  assign overflow   = overflow_q;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_ps2_line_buffer.sv
// Bench for ps2_line_buffer: directed scenarios followed by random scan-code
// traffic, compared against a queue-of-characters model of the line editor.
module tb_ps2_line_buffer;

  localparam int MAX_CHARS = 32;
  localparam int W         = 8 * MAX_CHARS;

  logic         clock;
  logic         resetn;
  logic [7:0]   ps2_byte;
  logic         ps2_byte_valid;
  logic [W-1:0] input_line;
  logic         line_ready;
  logic [W-1:0] edit_line;
  logic [5:0]   edit_len;
  logic         overflow;
  logic [1:0]   fsm_state;

  ps2_line_buffer #(.MAX_CHARS(MAX_CHARS)) dut (
    .clock          (clock),
    .resetn         (resetn),
    .ps2_byte       (ps2_byte),
    .ps2_byte_valid (ps2_byte_valid),
    .input_line     (input_line),
    .line_ready     (line_ready),
    .edit_line      (edit_line),
    .edit_len       (edit_len),
    .overflow       (overflow),
    .fsm_state      (fsm_state)
  );

  // ---------------- clock / reset ----------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // ---------------- scoreboard state ----------------
  int           n_cmp  = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0]   key_map[logic [7:0]];
  logic [7:0]   m_chars[$];
  logic [W-1:0] m_committed;
  bit           m_ovf;
  bit           m_after_f0;
  bit           m_after_e0;

  logic [7:0] letter_codes[26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
    8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D, 8'h15, 8'h2D,
    8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
    8'h3D, 8'h3E, 8'h46};
  logic [7:0] pad_codes[10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74,
    8'h6C, 8'h75, 8'h7D};

  bit keypad_en;

  initial begin
`ifdef PS2_LINE_KEYPAD_EN
    keypad_en = 1'b1;
`else
    keypad_en = 1'b0;
`endif
    for (int i = 0; i < 26; i++) key_map[letter_codes[i]] = 8'(8'h41 + i);
    for (int i = 0; i < 10; i++) key_map[digit_codes[i]] = 8'(8'h30 + i);
    key_map[8'h29] = 8'h20;
    if (keypad_en)
      for (int i = 0; i < 10; i++) key_map[pad_codes[i]] = 8'(8'h30 + i);
  end

  function automatic logic [W-1:0] pack_line();
    logic [W-1:0] line;
    line = '0;
    for (int i = 0; i < MAX_CHARS; i++)
      line = {line[W-9:0], (i < m_chars.size()) ? m_chars[i] : 8'h00};
    return line;
  endfunction

  task automatic model_reset();
    m_chars.delete();
    m_committed = '0;
    m_ovf       = 1'b0;
    m_after_f0  = 1'b0;
    m_after_e0  = 1'b0;
  endtask

  task automatic model_enter();
    logic [W-1:0] line;
    if (m_chars.size() > 0) begin
      line = pack_line();
      exp_q.push_back(line);
      m_committed = line;
      m_chars.delete();
      m_ovf = 1'b0;
    end
  endtask

  task automatic model_step(input logic [7:0] b);
    if (m_after_f0) begin
      m_after_f0 = 1'b0;          // released key: byte swallowed
    end else if (b == 8'hF0) begin
      m_after_f0 = 1'b1;
      m_after_e0 = 1'b0;
    end else if (m_after_e0) begin
      m_after_e0 = 1'b0;          // extended make: only keypad Enter matters
      if (keypad_en && b == 8'h5A) model_enter();
    end else if (b == 8'hE0) begin
      m_after_e0 = 1'b1;
    end else if (key_map.exists(b)) begin
      if (m_chars.size() < MAX_CHARS) m_chars.push_back(key_map[b]);
      else                            m_ovf = 1'b1;
    end else if (b == 8'h66) begin
      if (m_chars.size() > 0) void'(m_chars.pop_back());
    end else if (b == 8'h76) begin
      m_chars.delete();
      m_ovf = 1'b0;
    end else if (b == 8'h5A) begin
      model_enter();
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic check_state(input string tag);
    chk({tag, ".edit_len"},   W'(edit_len), W'(m_chars.size()));
    chk({tag, ".edit_line"},  edit_line,    pack_line());
    chk({tag, ".overflow"},   W'(overflow), W'(m_ovf));
    chk({tag, ".input_line"}, input_line,   m_committed);
  endtask

  // Present one byte for one cycle; successive calls give back-to-back strobes
  task automatic send(input logic [7:0] b);
    ps2_byte       = b;
    ps2_byte_valid = 1'b1;
    model_step(b);
    @(negedge clock);
    ps2_byte_valid = 1'b0;
    check_state("byte");
  endtask

  task automatic send_list(input logic [7:0] bytes[$]);
    foreach (bytes[i]) send(bytes[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (resetn === 1'b1 && line_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_line_ready", W'(line_ready), W'(0));
      end else begin
        chk("commit_line", input_line, exp_q.pop_front());
      end
    end
  end

  // ---------------- stimulus ----------------
  logic [7:0] seq[$];
  int         pulses_before;

  initial begin
    resetn         = 1'b0;
    ps2_byte       = 8'h00;
    ps2_byte_valid = 1'b0;
    model_reset();
    idle(3);
    chk("reset.input_line", input_line,      '0);
    chk("reset.edit_line",  edit_line,       '0);
    chk("reset.edit_len",   W'(edit_len),    '0);
    chk("reset.line_ready", W'(line_ready),  '0);
    chk("reset.overflow",   W'(overflow),    '0);
    resetn = 1'b1;
    idle(2);

    // "SET V 20" then Enter
    seq = '{8'h1B, 8'h24, 8'h2C, 8'h29, 8'h2A, 8'h29, 8'h1E, 8'h45, 8'h5A};
    send_list(seq);
    chk("set_v_20.line", W'(input_line[W-1 -: 64]), W'(64'h5345542056203230));
    chk("set_v_20.rest", W'(input_line[W-65:0]), '0);
    idle(2);

    // "FIRE" with break codes in between
    seq = '{8'h2B, 8'hF0, 8'h2B, 8'h43, 8'hF0, 8'h43, 8'h2D, 8'hF0, 8'h2D,
            8'h24, 8'hF0, 8'h24, 8'h5A};
    send_list(seq);
    chk("fire.line", W'(input_line[W-1 -: 32]), W'(32'h46495245));
    idle(1);

    // Fill past capacity, backspace, commit
    repeat (33) send(8'h1C);
    chk("full.overflow", W'(overflow), W'(1));
    send(8'h66);
    chk("bs.len", W'(edit_len), W'(31));
    send(8'h5A);
    chk("full_commit.ovf", W'(overflow), W'(0));
    idle(1);

    // Empty Enter, Backspace at zero, extended up arrow, then a normal key
    seq = '{8'h5A, 8'h66, 8'hE0, 8'h75, 8'h1C};
    send_list(seq);
    chk("noop.char0", W'(edit_line[W-1 -: 8]), W'(8'h41));
    send(8'h76);

    // Reset in the middle of a break prefix
    send(8'h1C);
    send(8'hF0);
    #2 resetn = 1'b0;
    #1;
    model_reset();
    chk("async_rst.edit_line", edit_line,    '0);
    chk("async_rst.edit_len",  W'(edit_len), '0);
    chk("async_rst.input",     input_line,   '0);
    @(negedge clock);
    resetn = 1'b1;
    idle(1);
    send(8'h1C);
    chk("after_rst.char0", W'(edit_line[W-1 -: 8]), W'(8'h41));
    send(8'h76);

    // Keypad digits and keypad Enter
    pulses_before = n_cmp;
    seq = '{8'h69, 8'h70, 8'hE0, 8'h5A};
    send_list(seq);
    if (keypad_en) chk("keypad.line", W'(input_line[W-1 -: 16]), W'(16'h3130));
    else           chk("keypad.len",  W'(edit_len), '0);
    send(8'h76);
    idle(2);

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      logic [7:0] b;
      r = $urandom_range(0, 99);
      if (r < 50) begin
        case ($urandom_range(0, 2))
          0: b = letter_codes[$urandom_range(0, 25)];
          1: b = digit_codes[$urandom_range(0, 9)];
          default: b = pad_codes[$urandom_range(0, 9)];
        endcase
      end else if (r < 53) b = 8'h29;
      else if (r < 63) b = 8'hF0;
      else if (r < 69) b = 8'hE0;
      else if (r < 76) b = 8'h66;
      else if (r < 78) b = 8'h76;
      else if (r < 86) b = 8'h5A;
      else             b = 8'($urandom_range(0, 255));
      send(b);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
    end

    idle(3);
    chk("pending_commits", W'(exp_q.size()), '0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
